// File: rtl/mu_modmul.sv
// mu_modmul: iterative multiplier with plain and modular (Blakley) modes.
// One coefficient pair per operation, start/done handshake.
module mu_modmul #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH-1:0] c,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int W2 = 2 * WIDTH;
    localparam int RW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [W2-1:0]    opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [RW-1:0]    r_q, r_d;
    logic [W2-1:0]    c_q, c_d;
    logic             err_q, err_d;

    logic [W2-1:0]    acc_nxt;
    logic [RW-1:0]    r_dbl;
    logic [RW-1:0]    r_s1;
    logic [RW-1:0]    r_s2;
    logic [RW-1:0]    m_ext;
    logic             op_err;

    // One iteration of each datapath; r stays below m so two subtractions suffice
    always_comb begin
        acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);
        m_ext   = {2'b00, m_q};
        r_dbl   = (r_q << 1) + (opa_q[WIDTH-1] ? {2'b00, opb_q} : '0);
        r_s1    = (r_dbl >= m_ext) ? r_dbl - m_ext : r_dbl;
        r_s2    = (r_s1 >= m_ext) ? r_s1 - m_ext : r_s1;
        op_err  = mode & ((m == '0) | (b >= m));
    end

    // Next-state, operand latching and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        m_d     = m_q;
        acc_d   = acc_q;
        r_d     = r_q;
        c_d     = c_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d = mode;
                    opa_d  = {{WIDTH{1'b0}}, a};
                    opb_d  = b;
                    m_d    = m;
                    acc_d  = '0;
                    r_d    = '0;
                    cnt_d  = CNT_W'(WIDTH);
                    err_d  = op_err;
                    if (op_err) begin
                        state_d = S_DONE;
                        c_d     = '0;
                    end else begin
                        state_d = S_COMPUTE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMPUTE: begin
                cnt_d = cnt_q - CNT_W'(1);
                opa_d = opa_q << 1;
                if (mode_q) begin
                    r_d = r_s2;
                end else begin
                    acc_d = acc_nxt;
                    opb_d = opb_q >> 1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    c_d = mode_q ? {{WIDTH{1'b0}}, r_s2[WIDTH-1:0]}
                                 : acc_nxt;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == S_COMPUTE);
    assign done = (state_q == S_DONE);
    assign c    = c_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mu_modmul.sv
// tb_mu_modmul: scoreboard bench for mu_modmul (WIDTH=32).
// Expected results come from a behavioural model queued at issue time.
module tb_mu_modmul;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] m;
    logic [63:0] c;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks;
    int n_fail;

    logic [64:0] exp_q[$];

    mu_modmul #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .mode (mode),
        .a    (a),
        .b    (b),
        .m    (m),
        .c    (c),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] model(input logic md,
                                          input logic [31:0] xa,
                                          input logic [31:0] xb,
                                          input logic [31:0] xm);
        logic [63:0] p;
        p = {32'd0, xa} * {32'd0, xb};
        if (md) begin
            if (xm == 0 || xb >= xm) return {1'b1, 64'd0};
            return {1'b0, p % {32'd0, xm}};
        end
        return {1'b0, p};
    endfunction

    // Called at a negedge: drive a request, it is accepted on the next posedge
    task automatic issue(input logic md, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [31:0] xm);
        start = 1'b1;
        mode  = md;
        a     = xa;
        b     = xb;
        m     = xm;
        exp_q.push_back(model(md, xa, xb, xm));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count negedges after the accept edge until done; lat=-1 on timeout
    task automatic wait_done(output int lat, output int bsy,
                             output logic [63:0] oc, output logic oe);
        lat = -1;
        bsy = 0;
        oc  = '0;
        oe  = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (busy) bsy++;
            if (done) begin
                lat = i;
                oc  = c;
                oe  = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (c !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_c got=%h want=0", c);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got busy=%b done=%b err=%b want 000",
                     busy, done, err);
        end
    endtask

    task automatic test_plain();
        logic [31:0] va[6];
        logic [31:0] vb[6];
        logic [64:0] e;
        logic [63:0] oc;
        logic        oe;
        int          lat;
        int          bsy;
        va[0] = 32'h1;        vb[0] = 32'h5;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'h3;
        for (int i = 3; i < 6; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issue(1'b0, va[i], vb[i], $urandom);
            wait_done(lat, bsy, oc, oe);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== 33) begin
                n_fail++;
                $display("FAIL plain_lat[%0d] got=%0d want=33", i, lat);
            end
            n_checks++;
            if (bsy !== 32) begin
                n_fail++;
                $display("FAIL plain_busy[%0d] got=%0d want=32", i, bsy);
            end
            n_checks++;
            if (oc !== e[63:0] || oe !== e[64]) begin
                n_fail++;
                $display("FAIL plain_c[%0d] got=%h/%b want=%h/%b",
                         i, oc, oe, e[63:0], e[64]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (c !== e[63:0] || done !== 1'b0) begin
            n_fail++;
            $display("FAIL plain_hold got c=%h done=%b want c=%h done=0",
                     c, done, e[63:0]);
        end
    endtask

    task automatic test_modular();
        logic [31:0] va[7];
        logic [31:0] vb[7];
        logic [31:0] vm[7];
        logic [64:0] e;
        logic [63:0] oc;
        logic        oe;
        int          lat;
        int          bsy;
        va[0] = 32'd7;        vb[0] = 32'd5;  vm[0] = 32'd13;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'd2;  vm[1] = 32'hFFFFFFFB;
        va[2] = 32'd0;        vb[2] = 32'd12; vm[2] = 32'd13;
        va[3] = 32'hFFFFFFFF; vb[3] = 32'hFFFFFFFE; vm[3] = 32'hFFFFFFFF;
        for (int i = 4; i < 7; i++) begin
            va[i] = $urandom;
            vm[i] = $urandom | 32'h1;
            vb[i] = $urandom % vm[i];
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            issue(1'b1, va[i], vb[i], vm[i]);
            wait_done(lat, bsy, oc, oe);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== 33 || bsy !== 32) begin
                n_fail++;
                $display("FAIL mod_timing[%0d] got lat=%0d busy=%0d want 33/32",
                         i, lat, bsy);
            end
            n_checks++;
            if (oc !== e[63:0] || oe !== e[64]) begin
                n_fail++;
                $display("FAIL mod_c[%0d] got=%h/%b want=%h/%b",
                         i, oc, oe, e[63:0], e[64]);
            end
        end
    endtask

    task automatic test_error();
        logic [64:0] e;
        logic [63:0] oc;
        logic        oe;
        int          lat;
        int          bsy;
        @(negedge clk);
        issue(1'b1, 32'd9, 32'd3, 32'd0);
        wait_done(lat, bsy, oc, oe);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 1 || bsy !== 0) begin
            n_fail++;
            $display("FAIL err_m0_timing got lat=%0d busy=%0d want 1/0",
                     lat, bsy);
        end
        n_checks++;
        if (oe !== 1'b1 || oc !== e[63:0]) begin
            n_fail++;
            $display("FAIL err_m0 got c=%h err=%b want c=0 err=1", oc, oe);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL err_hold got err=%b done=%b want 1/0", err, done);
        end
        issue(1'b1, 32'd4, 32'd13, 32'd13);
        wait_done(lat, bsy, oc, oe);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 1 || oe !== e[64] || oc !== e[63:0]) begin
            n_fail++;
            $display("FAIL err_b_ge_m got lat=%0d err=%b c=%h want 1/1/0",
                     lat, oe, oc);
        end
        @(negedge clk);
        issue(1'b1, 32'd6, 32'd5, 32'd11);
        wait_done(lat, bsy, oc, oe);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 33 || oe !== e[64] || oc !== e[63:0]) begin
            n_fail++;
            $display("FAIL err_clear got lat=%0d err=%b c=%h want 33/%b/%h",
                     lat, oe, oc, e[64], e[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] e;
        int          gap;
        int          k;
        logic [31:0] xa;
        logic [31:0] xb;
        @(negedge clk);
        xa = $urandom;
        xb = $urandom;
        start = 1'b1;
        mode  = 1'b0;
        a = xa;
        b = xb;
        m = 32'd0;
        exp_q.push_back(model(1'b0, xa, xb, 32'd0));
        k = 0;
        while (k < 4) begin
            gap = -1;
            for (int i = 1; i <= 200; i++) begin
                @(negedge clk);
                if (done) begin
                    gap = i;
                    break;
                end
            end
            e = exp_q.pop_front();
            n_checks++;
            if (gap !== 33) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d] got=%0d want=33", k, gap);
            end
            n_checks++;
            if (c !== e[63:0] || err !== e[64]) begin
                n_fail++;
                $display("FAIL b2b_c[%0d] got=%h/%b want=%h/%b",
                         k, c, err, e[63:0], e[64]);
            end
            k++;
            if (k < 4) begin
                xa = $urandom;
                xb = $urandom % 32'd1000 + 32'd1;
                mode = k[0];
                a = xa;
                b = xb;
                m = mode ? 32'd1009 : 32'd0;
                exp_q.push_back(model(mode, xa, xb, m));
            end else begin
                start = 1'b0;
            end
            if (gap < 0) break;
        end
    endtask

    task automatic test_ignore();
        logic [64:0] e;
        int          lat;
        lat = -1;
        @(negedge clk);
        issue(1'b1, 32'h1234567, 32'd77, 32'd101);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 12) begin
                start = 1'b1;
                mode  = 1'b0;
                a = 32'hDEADBEEF;
                b = 32'hCAFEF00D;
                m = 32'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 33 || c !== e[63:0] || err !== e[64]) begin
            n_fail++;
            $display("FAIL ignore got lat=%0d c=%h err=%b want 33/%h/%b",
                     lat, c, err, e[63:0], e[64]);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_idle got busy=%b done=%b want 0/0",
                     busy, done);
        end
    endtask

    task automatic test_mid_reset();
        logic [64:0] e;
        logic [63:0] oc;
        logic        oe;
        int          lat;
        int          bsy;
        int          seen;
        @(negedge clk);
        issue(1'b0, 32'hFFFF0001, 32'h12345, 32'd0);
        void'(exp_q.pop_front());
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (c !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got c=%h busy=%b done=%b err=%b want 0",
                     c, busy, done, err);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_nodone got=%0d want=0", seen);
        end
        issue(1'b0, 32'd3, 32'd4, 32'd0);
        wait_done(lat, bsy, oc, oe);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 33 || oc !== e[63:0] || oe !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got lat=%0d c=%h err=%b want 33/%h/0",
                     lat, oc, oe, e[63:0]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        m     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_plain();
        test_modular();
        test_error();
        test_back_to_back();
        test_ignore();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
